// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the shared combinational ALU and the response consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface alu_arbiter_if;
    logic        req0_valid_i;
    logic        req1_valid_i;
    logic        req0_ready_o;
    logic        req1_ready_o;
    logic [31:0] req0_src1_i;
    logic [31:0] req0_src2_i;
    logic [31:0] req1_src1_i;
    logic [31:0] req1_src2_i;
    logic [3:0]  req0_ctrl_i;
    logic [3:0]  req1_ctrl_i;
    logic [4:0]  req0_shamt_i;
    logic [4:0]  req1_shamt_i;

    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  alu_shamt_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;

    modport slave (
        input  req0_valid_i, req1_valid_i,
        output req0_ready_o, req1_ready_o,
        input  req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i,
        input  req0_ctrl_i, req1_ctrl_i, req0_shamt_i, req1_shamt_i,
        output alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
        input  alu_result_i, alu_zero_i,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_id_o, rsp_result_o, rsp_zero_o
    );

    modport master (
        output req0_valid_i, req1_valid_i,
        input  req0_ready_o, req1_ready_o,
        output req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i,
        output req0_ctrl_i, req1_ctrl_i, req0_shamt_i, req1_shamt_i,
        input  alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
        output alu_result_i, alu_zero_i,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_id_o, rsp_result_o, rsp_zero_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Mult ops (ctrl 4'b0011) stay in EXEC for MULT_LAT cycles; everything else takes one cycle.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for a request; ready asserted for the granted requester
//   ST_EXEC   | operand registers drive the ALU; counting down the op latency
//   ST_RESP   | response held on rsp_*_o until the consumer takes it
module alu_arbiter #(
    parameter int unsigned MULT_LAT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_CTRL_MULT = 4'b0011;
    localparam logic [3:0] LP_MULT_LAST = 4'(MULT_LAT - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic [3:0]  r_cnt;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [3:0]  r_ctrl;
    logic [4:0]  r_shamt;
    logic        r_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_accept_id;
    logic        w_exec_last;
    logic [31:0] w_sel_src1;
    logic [31:0] w_sel_src2;
    logic [3:0]  w_sel_ctrl;
    logic [4:0]  w_sel_shamt;

    // On a tie the requester that did not win last time goes first.
    assign w_idle      = (r_state == ST_IDLE) && !rst_i;
    assign w_grant0    = w_idle && bus.req0_valid_i && (!bus.req1_valid_i || r_last_grant);
    assign w_grant1    = w_idle && bus.req1_valid_i && (!bus.req0_valid_i || !r_last_grant);
    assign w_accept    = w_grant0 || w_grant1;
    assign w_accept_id = w_grant1;

    assign w_sel_src1  = w_accept_id ? bus.req1_src1_i  : bus.req0_src1_i;
    assign w_sel_src2  = w_accept_id ? bus.req1_src2_i  : bus.req0_src2_i;
    assign w_sel_ctrl  = w_accept_id ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
    assign w_sel_shamt = w_accept_id ? bus.req1_shamt_i : bus.req0_shamt_i;

    assign w_exec_last = (r_ctrl == LP_CTRL_MULT) ? (r_cnt == LP_MULT_LAST) : 1'b1;

    assign bus.req0_ready_o = w_grant0;
    assign bus.req1_ready_o = w_grant1;

    assign bus.alu_src1_o   = r_src1;
    assign bus.alu_src2_o   = r_src2;
    assign bus.alu_ctrl_o   = r_ctrl;
    assign bus.alu_shamt_o  = r_shamt;

    assign bus.rsp_valid_o  = r_rsp_valid;
    assign bus.rsp_id_o     = r_rsp_id;
    assign bus.rsp_result_o = r_rsp_result;
    assign bus.rsp_zero_o   = r_rsp_zero;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_ctrl       <= '0;
            r_shamt      <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src1       <= w_sel_src1;
                        r_src2       <= w_sel_src2;
                        r_ctrl       <= w_sel_ctrl;
                        r_shamt      <= w_sel_shamt;
                        r_id         <= w_accept_id;
                        r_last_grant <= w_accept_id;
                        r_cnt        <= '0;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_exec_last) begin
                        r_rsp_result <= bus.alu_result_i;
                        r_rsp_zero   <= bus.alu_zero_i;
                        r_rsp_id     <= r_id;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked against the DUT every cycle,
// plus directed scenarios with hand-computed latencies, results and grant orders.
module tb_alu_arbiter;

    localparam int MULT_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    alu_arbiter_if bus ();

    alu_arbiter #(.MULT_LAT(MULT_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c, input logic [4:0] sh);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return a * b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return a << sh;
            4'b1000: return a >> sh;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result_i = alu_fn(bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o, bus.alu_shamt_o);
    assign bus.alu_zero_i   = (bus.alu_result_i == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errs++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Transaction model: an op occupies the ALU for its latency, then a response waits for the consumer.
    bit          m_live = 1'b0;
    int          m_exec_left = 0;
    bit          m_rsp_pend = 1'b0;
    bit          m_last = 1'b1;
    logic [31:0] m_src1 = '0, m_src2 = '0, m_res = '0;
    logic [3:0]  m_ctrl = '0;
    logic [4:0]  m_shamt = '0;
    bit          m_id = 1'b0, m_rid = 1'b0, m_zero = 1'b0;

    function automatic bit exp_ready(input int k);
        bit free;
        free = m_live && (m_exec_left == 0) && !m_rsp_pend && !rst;
        if (k == 0) return free && bus.req0_valid_i && (!bus.req1_valid_i || m_last);
        return free && bus.req1_valid_i && (!bus.req0_valid_i || !m_last);
    endfunction

    initial forever begin
        bit g0, g1;
        @(posedge clk);
        g0 = exp_ready(0);
        g1 = exp_ready(1);
        cyc++;
        if (rst) begin
            m_live = 1'b1; m_exec_left = 0; m_rsp_pend = 1'b0; m_last = 1'b1;
            m_src1 = '0; m_src2 = '0; m_ctrl = '0; m_shamt = '0; m_id = 1'b0;
            m_res = '0; m_zero = 1'b0; m_rid = 1'b0;
        end else if (m_live) begin
            if (m_rsp_pend) begin
                if (bus.rsp_ready_i) m_rsp_pend = 1'b0;
            end else if (m_exec_left > 0) begin
                if (m_exec_left == 1) begin
                    m_res = alu_fn(m_src1, m_src2, m_ctrl, m_shamt);
                    m_zero = (m_res == 32'd0);
                    m_rid = m_id;
                    m_rsp_pend = 1'b1;
                end
                m_exec_left--;
            end else if (g0 || g1) begin
                m_src1  = g1 ? bus.req1_src1_i  : bus.req0_src1_i;
                m_src2  = g1 ? bus.req1_src2_i  : bus.req0_src2_i;
                m_ctrl  = g1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
                m_shamt = g1 ? bus.req1_shamt_i : bus.req0_shamt_i;
                m_id = g1;
                m_last = g1;
                m_exec_left = (m_ctrl == 4'b0011) ? MULT_LAT : 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("ready0", bus.req0_ready_o, exp_ready(0));
            chk("ready1", bus.req1_ready_o, exp_ready(1));
            chk("one_ready", bus.req0_ready_o & bus.req1_ready_o, 0);
            chk("alu_src1", bus.alu_src1_o, m_src1);
            chk("alu_src2", bus.alu_src2_o, m_src2);
            chk("alu_ctrl", bus.alu_ctrl_o, m_ctrl);
            chk("alu_shamt", bus.alu_shamt_o, m_shamt);
            chk("rsp_valid", bus.rsp_valid_o, m_rsp_pend);
            chk("rsp_id", bus.rsp_id_o, m_rid);
            chk("rsp_result", bus.rsp_result_o, m_res);
            chk("rsp_zero", bus.rsp_zero_o, m_zero);
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [4:0] sh);
        if (k == 0) begin
            bus.req0_valid_i = v; bus.req0_src1_i = a; bus.req0_src2_i = b;
            bus.req0_ctrl_i = c; bus.req0_shamt_i = sh;
        end else begin
            bus.req1_valid_i = v; bus.req1_src1_i = a; bus.req1_src2_i = b;
            bus.req1_ctrl_i = c; bus.req1_shamt_i = sh;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        go();
        go();
        rst = 1'b0;
    endtask

    task automatic wait_accept(input int k, output int t);
        t = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((k == 0 && bus.req0_ready_o) || (k == 1 && bus.req1_ready_o)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("accept_wait");
    endtask

    task automatic wait_any(output int id, output int t);
        t = -1;
        id = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.req0_ready_o || bus.req1_ready_o) begin
                id = bus.req1_ready_o ? 1 : 0;
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("grant_wait");
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("rsp_wait");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tr, ta2, gid;
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        set_req(0, 1'b0, 0, 0, 4'd0, 5'd0);
        set_req(1, 1'b0, 0, 0, 4'd0, 5'd0);
        bus.rsp_ready_i = 1'b1;
        do_reset();

        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_alu_src1", bus.alu_src1_o, 0);
        chk("rst_rsp_result", bus.rsp_result_o, 0);

        // add 5 + 7 from requester 0
        go();
        set_req(0, 1'b1, 32'd5, 32'd7, 4'b0000, 5'd0);
        wait_accept(0, ta);
        go();
        bus.req0_valid_i = 1'b0;
        wait_rsp(tr);
        chk("add_latency", tr - ta, 2);
        chk("add_id", bus.rsp_id_o, 0);
        chk("add_result", bus.rsp_result_o, 32'd12);
        chk("add_zero", bus.rsp_zero_o, 0);

        // tie after reset: requester 0 first, then 1
        go();
        do_reset();
        set_req(0, 1'b1, 32'd3, 32'd3, 4'b0001, 5'd0);
        set_req(1, 1'b1, 32'd1, 32'd2, 4'b0101, 5'd0);
        wait_accept(0, ta);
        go();
        bus.req0_valid_i = 1'b0;
        wait_rsp(tr);
        chk("sub_id", bus.rsp_id_o, 0);
        chk("sub_result", bus.rsp_result_o, 32'd0);
        chk("sub_zero", bus.rsp_zero_o, 1);
        wait_accept(1, ta);
        chk("or_accept_gap", ta - tr, 1);
        go();
        bus.req1_valid_i = 1'b0;
        wait_rsp(tr);
        chk("or_id", bus.rsp_id_o, 1);
        chk("or_result", bus.rsp_result_o, 32'd3);
        chk("or_zero", bus.rsp_zero_o, 0);

        // multi-cycle mult from requester 1
        go();
        set_req(1, 1'b1, 32'd6, 32'd7, 4'b0011, 5'd0);
        wait_accept(1, ta);
        go();
        bus.req1_valid_i = 1'b0;
        tr = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin
                tr = cyc;
                break;
            end
            chk("mult_ctrl_exec", bus.alu_ctrl_o, 4'b0011);
        end
        if (tr < 0) fail_now("mult_rsp_wait");
        chk("mult_latency", tr - ta, 5);
        chk("mult_result", bus.rsp_result_o, 32'd42);
        chk("mult_id", bus.rsp_id_o, 1);
        chk("mult_ctrl_resp", bus.alu_ctrl_o, 4'b0011);

        // both requesters held: grants alternate
        go();
        set_req(0, 1'b1, 32'd1, 32'd1, 4'b0000, 5'd0);
        set_req(1, 1'b1, 32'd10, 32'd4, 4'b0001, 5'd0);
        for (int g = 0; g < 4; g++) begin
            wait_any(gid, ta);
            chk("rr_grant", gid, exp_g[g]);
            chk("rr_single", bus.req0_ready_o & bus.req1_ready_o, 0);
        end
        go();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        wait_rsp(tr);
        chk("rr_last_result", bus.rsp_result_o, 32'd6);

        // consumer stalls 3 cycles; requester 1 waits behind the response
        go();
        set_req(0, 1'b1, 32'h0000F0F0, 32'h00000FF0, 4'b0110, 5'd0);
        set_req(1, 1'b1, 32'd1, 32'd0, 4'b0111, 5'd4);
        wait_accept(0, ta);
        go();
        bus.req0_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        wait_rsp(tr);
        chk("stall_result", bus.rsp_result_o, 32'h0000FF00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid_o, 1);
            chk("stall_hold", bus.rsp_result_o, 32'h0000FF00);
            chk("stall_id", bus.rsp_id_o, 0);
            chk("stall_no_accept", bus.req1_ready_o, 0);
        end
        go();
        bus.rsp_ready_i = 1'b1;
        wait_accept(1, ta2);
        chk("stall_resume", ta2 - tr, 4);
        go();
        bus.req1_valid_i = 1'b0;
        wait_rsp(tr);
        chk("sll_result", bus.rsp_result_o, 32'd16);
        chk("sll_id", bus.rsp_id_o, 1);

        // reset in the second EXEC cycle of a mult abandons it
        go();
        set_req(0, 1'b1, 32'd9, 32'd9, 4'b0011, 5'd0);
        wait_accept(0, ta);
        go();
        bus.req0_valid_i = 1'b0;
        go();
        rst = 1'b1;
        bus.req1_valid_i = 1'b1;
        @(negedge clk);
        chk("rst_ready1", bus.req1_ready_o, 0);
        go();
        rst = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", bus.alu_ctrl_o, 0);
        chk("abort_valid", bus.rsp_valid_o, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid_o, 0);
        end

        // undefined op code passes through, ALU returns 0
        go();
        set_req(1, 1'b1, 32'd123, 32'd456, 4'b1111, 5'd3);
        wait_accept(1, ta);
        go();
        bus.req1_valid_i = 1'b0;
        wait_rsp(tr);
        chk("undef_latency", tr - ta, 2);
        chk("undef_ctrl", bus.alu_ctrl_o, 4'b1111);
        chk("undef_result", bus.rsp_result_o, 32'd0);
        chk("undef_zero", bus.rsp_zero_o, 1);

        go();
        go();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MULT_LAT, default 4, meaning EXEC-state cycles spent on a mult op (ctrl 4'b0011); legal range 1..15.
REQ-002 clk_i  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 req0_valid_i / req1_valid_i  input  1 each  requester k has an op pending.
REQ-005 req0_ready_o / req1_ready_o  output  1 each  arbiter accepts requester k's op this cycle.
REQ-006 req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i  input  32 each  operands.
REQ-007 req0_ctrl_i, req1_ctrl_i  input  4 each  ALU op code; req0_shamt_i, req1_shamt_i  input  5 each  shift amount.
REQ-008 alu_src1_o, alu_src2_o  output  32 each; alu_ctrl_o  output  4; alu_shamt_o  output  5  drive the shared ALU.
REQ-009 alu_result_i  input  32; alu_zero_i  input  1  combinational ALU outputs.
REQ-010 rsp_valid_o  output  1  response available; rsp_ready_i  input  1  consumer takes response.
REQ-011 rsp_id_o  output  1  requester index of response; rsp_result_o  output  32; rsp_zero_o  output  1.

Function
REQ-012 FSM states: IDLE, EXEC, RESP; one op in flight at a time, no overlap.
REQ-013 IDLE: grant = requester with valid set; both valid -> requester not equal to last_grant wins (round-robin).
REQ-014 reqK_ready_o = 1 only in IDLE and only for the granted requester; combinational from valids and last_grant; at most one ready high per cycle.
REQ-015 Accept = valid & ready in IDLE: latch src1, src2, ctrl, shamt, id into operand registers, update last_grant to id, go EXEC, clear cycle counter.
REQ-016 IDLE with no valid: remain IDLE, registers unchanged.
REQ-017 alu_*_o driven only from operand registers (never directly from requester inputs); held stable throughout EXEC and RESP.
REQ-018 EXEC length L = MULT_LAT when latched ctrl == 4'b0011, else 1; 4-bit counter increments each EXEC cycle.
REQ-019 Last EXEC cycle: capture alu_result_i into rsp_result_o, alu_zero_i into rsp_zero_o, latched id into rsp_id_o; go RESP.
REQ-020 RESP: rsp_valid_o = 1; rsp_result_o/rsp_zero_o/rsp_id_o stable until rsp_ready_i = 1; then go IDLE next cycle.
REQ-021 Latency: accept in cycle T -> rsp_valid_o first high in cycle T+L+1; next accept no earlier than the cycle after the RESP handshake.
REQ-022 Unknown ctrl codes forwarded unchanged; response carries whatever the ALU returns (0 for undefined codes), no error flag.
REQ-023 Requester valid dropping before acceptance: no op issued, no state change; a valid held while the other requester is served is granted at the next IDLE.
REQ-024 Starvation bound: a continuously asserted requester is accepted within 2 grants.

Reset
REQ-025 rst_i = 1 at a clock edge forces state IDLE, counter 0, last_grant 1 (requester 0 wins first tie), rsp_valid_o 0, rsp_id_o 0, rsp_result_o 0, rsp_zero_o 0, operand registers 0 (alu_*_o = 0).
REQ-026 Reset mid-EXEC or mid-RESP abandons the op; no response emitted; ready outputs 0 while rst_i = 1.

Verification
REQ-027 Req0 only, add 5 + 7, rsp_ready_i held 1 -> rsp_valid_o high 2 cycles after accept, rsp_id_o 0, result 12, zero 0.
REQ-028 Both valid after reset, req0 sub 3 - 3, req1 or 1 | 2 -> req0 served first (result 0, zero 1), then req1 (result 3, id 1).
REQ-029 Req1 mult 6 * 7 with MULT_LAT 4 -> rsp_valid_o 5 cycles after accept, result 42; alu_ctrl_o stable 4'b0011 through EXEC.
REQ-030 Both valid continuously, rsp_ready_i 1 -> grants alternate 0,1,0,1; never two readies in one cycle.
REQ-031 RESP with rsp_ready_i low 3 cycles -> response fields stable, no new accept; accept resumes cycle after handshake.
REQ-032 rst_i asserted during mult EXEC cycle 2 -> next cycle IDLE, rsp_valid_o 0, no response for that op.
